matvec_ctrl: RTL and testbench

Sequencer and accumulator bank for the 8x8 by 8 matrix-vector multiply. It sits downstream of the Avalon-MM load block. Once that block asserts its load-complete strobe, `matvec_ctrl` steps a column counter across the loaded A matrix and B vector and drives eight row MAC units. It then presents the result vector C = A·B to a consumer under a valid/ready handshake.

---
 rtl/matvec_pkg.sv | 17 +
 rtl/matvec_ctrl_mac.sv | 40 ++++
 rtl/matvec_ctrl.sv | 97 +++++++++
 tb/tb_matvec_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared sizing, state encoding and array types for the matrix-vector sequencer.
package matvec_pkg;

  localparam int unsigned DIM    = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned COL_W  = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, MAC, VALID} mv_state_t;

  typedef logic [DATA_W-1:0]        operand_t;
  typedef logic [ACC_W-1:0]         acc_t;
  typedef operand_t [DIM-1:0][DIM-1:0] a_mat_t;
  typedef operand_t [DIM-1:0]       b_vec_t;
  typedef acc_t [DIM-1:0]           c_vec_t;

endpackage

// File: rtl/matvec_ctrl_mac.sv
// Single row multiply-accumulate cell: clear has priority over accumulate.
module mac_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2*DATA_W-1:0] prod;

  // Next accumulator value: clear, accumulate the unsigned product, or hold.
  always_comb begin
    prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matvec_ctrl.sv
// Sequencer for the DIM x DIM by DIM matrix-vector multiply: clears the row
// accumulators, steps one column per cycle, then holds C under valid/ready.
module matvec_ctrl #(
  parameter int unsigned DIM    = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [DIM-1:0][DIM-1:0][DATA_W-1:0] a_matrix,
  input  logic [DIM-1:0][DATA_W-1:0]          b_vector,
  output logic                                busy,
  output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] col,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [DIM-1:0][ACC_W-1:0]           c_vector
);

  import matvec_pkg::mv_state_t;
  import matvec_pkg::IDLE;
  import matvec_pkg::CLEAR;
  import matvec_pkg::MAC;
  import matvec_pkg::VALID;

  localparam int unsigned COL_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DIM - 1);

  mv_state_t        state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             clr, en;

  // State and column registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Next state, column stepping, accumulator controls and handshake outputs.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    clr       = 1'b0;
    en        = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        clr     = 1'b1;
        col_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        busy = 1'b1;
        en   = 1'b1;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = VALID;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      VALID: begin
        res_valid = 1'b1;
        if (res_ready) state_d = start ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    mac_unit #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en (en),
      .a  (a_matrix[i][col_q]),
      .b  (b_vector[col_q]),
      .acc(c_vector[i])
    );
  end

  assign col = col_q;

endmodule

// File: tb/tb_matvec_ctrl.sv
// Self-checking bench for matvec_ctrl against a plain-arithmetic dot-product model.
module tb_matvec_ctrl;
  import matvec_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, res_ready;
  a_mat_t     a_matrix;
  b_vec_t     b_vector;
  logic       busy, res_valid;
  logic [COL_W-1:0] col;
  c_vec_t     c_vector;

  int a_m [DIM][DIM];
  int b_v [DIM];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matvec_ctrl #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_matrix(a_matrix), .b_vector(b_vector),
    .busy(busy), .col(col), .res_valid(res_valid), .res_ready(res_ready), .c_vector(c_vector)
  );

  task automatic apply_ops();
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) a_matrix[i][k] = DATA_W'(a_m[i][k]);
      b_vector[i] = DATA_W'(b_v[i]);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) a_m[i][k] = int'($urandom_range(0, 255));
      b_v[i] = int'($urandom_range(0, 255));
    end
    apply_ops();
  endtask

  function automatic c_vec_t model();
    c_vec_t r;
    for (int i = 0; i < DIM; i++) begin
      longint s = 0;
      for (int k = 0; k < DIM; k++) s += longint'(a_m[i][k]) * longint'(b_v[k]);
      r[i] = ACC_W'(s);
    end
    return r;
  endfunction

  // Present start for one edge; returns at the falling edge just after the sampling edge.
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until res_valid is seen (bounded) and cycles with busy high.
  task automatic wait_valid(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    forever begin
      if (busy) busy_cnt++;
      if (res_valid || edges >= 40) break;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    int e, b;
    c_vec_t exp;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    rand_ops();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    n_cmp++; if (col !== '0) begin n_err++; $display("FAIL reset_col: got %0d want 0", col); end
    n_cmp++; if (c_vector !== '0) begin n_err++; $display("FAIL reset_c: got %h want 0", c_vector); end
    rst = 1'b0;
    // Reset must win over an accepting handshake with start pending.
    launch();
    wait_valid(e, b);
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL reset_prep_valid: got %b want 1", res_valid); end
    exp = model();
    n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL reset_prep_c: got %h want %h", c_vector, exp); end
    res_ready = 1'b1; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_in_valid: got valid=%b busy=%b want 0 0", res_valid, busy); end
    n_cmp++; if (c_vector !== '0) begin n_err++; $display("FAIL reset_in_valid_c: got %h want 0", c_vector); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_identity();
    int e, b;
    c_vec_t exp;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) a_m[i][k] = (i == k) ? 1 : 0;
      b_v[i] = i + 1;
      exp[i] = ACC_W'(i + 1);
    end
    apply_ops();
    res_ready = 1'b1;
    launch();
    wait_valid(e, b);
    n_cmp++; if (e !== 9) begin n_err++; $display("FAIL identity_latency: got %0d want 9", e); end
    n_cmp++; if (b !== 9) begin n_err++; $display("FAIL identity_busy_cycles: got %0d want 9", b); end
    n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL identity_c: got %h want %h", c_vector, exp); end
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL identity_accept: got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_all_ff();
    int e, b;
    c_vec_t exp;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) a_m[i][k] = 255;
      b_v[i] = 255;
      exp[i] = 24'h07F008;
    end
    apply_ops();
    res_ready = 1'b1;
    launch();
    wait_valid(e, b);
    n_cmp++; if (e !== 9) begin n_err++; $display("FAIL allff_latency: got %0d want 9", e); end
    n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL allff_c: got %h want %h", c_vector, exp); end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_stall();
    int e, b, bad;
    c_vec_t exp;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) a_m[i][k] = i + k;
      b_v[i] = i + 1;
    end
    apply_ops();
    exp = model();
    res_ready = 1'b0;
    launch();
    wait_valid(e, b);
    n_cmp++; if (e !== 9) begin n_err++; $display("FAIL stall_latency: got %0d want 9", e); end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      rand_ops();
      if (res_valid !== 1'b1 || c_vector !== exp) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles want 0 (c=%h want %h)", bad, c_vector, exp); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stall_accept: got valid=%b busy=%b want 0 0", res_valid, busy); end
    n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL stall_c_kept: got %h want %h", c_vector, exp); end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int e1, e2, b;
    c_vec_t exp1, exp2;
    rand_ops();
    exp1 = model();
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_valid(e1, b);
    n_cmp++; if (e1 !== 9) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 9", e1); end
    n_cmp++; if (c_vector !== exp1) begin n_err++; $display("FAIL b2b_first_c: got %h want %h", c_vector, exp1); end
    rand_ops();
    exp2 = model();
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_turnaround: got valid=%b busy=%b want 0 1", res_valid, busy); end
    wait_valid(e2, b);
    start = 1'b0;
    n_cmp++; if (e2 + 1 !== 10) begin n_err++; $display("FAIL b2b_interval: got %0d want 10", e2 + 1); end
    n_cmp++; if (c_vector !== exp2) begin n_err++; $display("FAIL b2b_second_c: got %h want %h", c_vector, exp2); end
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_idle: got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_abort();
    int e, b;
    c_vec_t exp;
    rand_ops();
    res_ready = 1'b1;
    launch();
    repeat (4) @(negedge clk);
    n_cmp++; if (col !== COL_W'(3)) begin n_err++; $display("FAIL abort_col: got %0d want 3", col); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL abort_flags: got busy=%b valid=%b want 0 0", busy, res_valid); end
    n_cmp++; if (c_vector !== '0 || col !== '0) begin n_err++; $display("FAIL abort_clear: got c=%h col=%0d want 0 0", c_vector, col); end
    rand_ops();
    exp = model();
    launch();
    wait_valid(e, b);
    n_cmp++; if (e !== 9) begin n_err++; $display("FAIL abort_rerun_latency: got %0d want 9", e); end
    n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL abort_rerun_c: got %h want %h", c_vector, exp); end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_start_mid_mac();
    int p, e, b, extra;
    c_vec_t exp;
    rand_ops();
    exp = model();
    res_ready = 1'b1;
    launch();
    p = int'($urandom_range(1, 8));
    repeat (p) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(e, b);
    n_cmp++; if (p + 1 + e !== 9) begin n_err++; $display("FAIL midstart_latency: got %0d want 9", p + 1 + e); end
    n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL midstart_c: got %h want %h", c_vector, exp); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    res_ready = 1'b0;
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL midstart_dropped: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_random();
    int e, b, d;
    c_vec_t exp;
    for (int j = 0; j < 6; j++) begin
      rand_ops();
      exp = model();
      res_ready = 1'b0;
      d = int'($urandom_range(0, 5));
      launch();
      wait_valid(e, b);
      repeat (d) @(negedge clk);
      n_cmp++; if (e !== 9 || res_valid !== 1'b1) begin n_err++; $display("FAIL random_valid[%0d]: got edges=%0d valid=%b want 9 1", j, e, res_valid); end
      n_cmp++; if (c_vector !== exp) begin n_err++; $display("FAIL random_c[%0d]: got %h want %h", j, c_vector, exp); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL random_accept[%0d]: got %b want 0", j, res_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ff();
    test_stall();
    test_back_to_back();
    test_abort();
    test_start_mid_mac();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
